// File: rtl/delay_and_sum_stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : delay_and_sum_stall_watchdog
// Description : Per-channel AXI-Stream stall counters with a programmable trip
//               threshold, one-shot report handshake and a sticky alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_and_sum_stall_watchdog #(
    parameter int NUM_CH = 10,
    parameter int CNT_W  = 16,
    parameter int CH_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  threshold,
    input  logic [NUM_CH-1:0] axis_block_sigs,
    input  logic              inst_idle,
    input  logic              clear,
    output logic              block,
    output logic              alarm,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [CH_W-1:0]   report_ch,
    output logic [CNT_W-1:0]  report_cycles,
    output logic [7:0]        trip_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
    localparam logic [7:0]       C_TRIP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WATCH   = 2'd1,
        ST_ALARM   = 2'd2,
        ST_LATCHED = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_block;
    logic              r_alarm;
    logic              r_report_valid;
    logic [CH_W-1:0]   r_report_ch;
    logic [CNT_W-1:0]  r_report_cycles;
    logic [7:0]        r_trip_count;

    logic [CNT_W-1:0]  r_cnt      [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_next [NUM_CH];

    logic              w_trip_found;
    logic [CH_W-1:0]   w_trip_ch;
    logic [CNT_W-1:0]  w_trip_cycles;
    logic              w_cnt_clr;
    logic              w_cnt_load;

    // Candidate counts; the descending scan leaves the lowest tripping index.
    always_comb begin
        w_trip_found  = 1'b0;
        w_trip_ch     = '0;
        w_trip_cycles = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (inst_idle || !axis_block_sigs[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == C_CNT_MAX) begin
                w_cnt_next[i] = C_CNT_MAX;
            end else begin
                w_cnt_next[i] = r_cnt[i] + 1'b1;
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((threshold != '0) && (w_cnt_next[i] >= threshold)) begin
                w_trip_found  = 1'b1;
                w_trip_ch     = CH_W'(i);
                w_trip_cycles = w_cnt_next[i];
            end
        end
    end

    assign w_cnt_clr  = !enable || (r_state == ST_IDLE) || clear;
    assign w_cnt_load = (r_state == ST_WATCH);

    // Counters only advance in WATCH; ALARM and LATCHED hold them frozen.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset || w_cnt_clr) begin
                r_cnt[i] <= '0;
            end else if (w_cnt_load) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_block         <= 1'b0;
            r_alarm         <= 1'b0;
            r_report_valid  <= 1'b0;
            r_report_ch     <= '0;
            r_report_cycles <= '0;
            r_trip_count    <= '0;
        end else begin
            r_block <= |axis_block_sigs;
            if (!enable) begin
                // Report fields are kept so software can still read them.
                r_state        <= ST_IDLE;
                r_alarm        <= 1'b0;
                r_report_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_WATCH;
                    end
                    ST_WATCH: begin
                        if (!clear && w_trip_found) begin
                            r_state         <= ST_ALARM;
                            r_alarm         <= 1'b1;
                            r_report_valid  <= 1'b1;
                            r_report_ch     <= w_trip_ch;
                            r_report_cycles <= w_trip_cycles;
                            if (r_trip_count != C_TRIP_MAX) begin
                                r_trip_count <= r_trip_count + 8'd1;
                            end
                        end
                    end
                    ST_ALARM: begin
                        if (clear) begin
                            r_state        <= ST_WATCH;
                            r_alarm        <= 1'b0;
                            r_report_valid <= 1'b0;
                        end else if (report_ready) begin
                            r_state        <= ST_LATCHED;
                            r_report_valid <= 1'b0;
                        end
                    end
                    ST_LATCHED: begin
                        if (clear) begin
                            r_state <= ST_WATCH;
                            r_alarm <= 1'b0;
                        end
                    end
                    default: begin
                        r_state        <= ST_IDLE;
                        r_alarm        <= 1'b0;
                        r_report_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign block         = r_block;
    assign alarm         = r_alarm;
    assign report_valid  = r_report_valid;
    assign report_ch     = r_report_ch;
    assign report_cycles = r_report_cycles;
    assign trip_count    = r_trip_count;

endmodule
`default_nettype wire
